// File: rtl/cpu6_ifu_prefetch_pkg.sv
// Shared constants and FSM state type for the cpu6 instruction-fetch prefetcher.
package cpu6_ifu_prefetch_pkg;

    localparam int unsigned CPU6_XLEN      = 32;
    localparam int unsigned CPU6_IFU_DEPTH = 4;
    localparam logic [31:0] CPU6_NOP       = 32'h0000_0013;

    typedef enum logic [1:0] {
        IFU_BOOT  = 2'd0,
        IFU_FETCH = 2'd1,
        IFU_HOLD  = 2'd2
    } ifu_state_e;

endpackage

// File: rtl/cpu6_ifu_fifo.sv
// Synchronous FIFO with single-cycle flush; head word is read straight from storage.
module cpu6_ifu_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned AW = $clog2(DEPTH),
    localparam int unsigned CW = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
    assign dout    = mem[rptr];

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + AW'(1);
            if (do_pop)  rptr <= rptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wptr] <= din;
    end

endmodule

// File: rtl/cpu6_ifu_prefetch.sv
// In-order instruction prefetcher: issues word fetches under a credit limit, buffers
// returned words with their PCs, and flushes/refetches on an execute-stage redirect.
module cpu6_ifu_prefetch
    import cpu6_ifu_prefetch_pkg::*;
#(
    parameter int unsigned     XLEN     = CPU6_XLEN,
    parameter int unsigned     DEPTH    = CPU6_IFU_DEPTH,
    parameter int unsigned     MAX_OUT  = 2,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [XLEN-1:0] imem_rdata_i,
    output logic            instr_valid_o,
    output logic [XLEN-1:0] instr_o,
    output logic [XLEN-1:0] instr_pc_o,
    input  logic            instr_ready_i
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned SW = CW + 1;
    localparam int unsigned OW = $clog2(MAX_OUT + 1);
    localparam int unsigned TW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

    ifu_state_e        state;
    ifu_state_e        state_n;
    logic [XLEN-1:0]   fpc;
    logic [OW-1:0]     inflight;
    logic [OW-1:0]     inflight_n;
    logic [OW-1:0]     discard;
    logic [OW-1:0]     discard_n;
    logic [OW-1:0]     live_n;
    logic [CW-1:0]     count;
    logic [CW-1:0]     count_n;
    logic              credit_ok;
    logic              req_n;
    logic              hs;
    logic              push;
    logic              pop;
    logic [2*XLEN-1:0] fifo_dout;
    logic [XLEN-1:0]   tag [MAX_OUT];
    logic [TW-1:0]     tw;
    logic [TW-1:0]     tr;

    assign hs   = imem_req_o && imem_gnt_i;
    assign push = imem_rvalid_i && (discard == '0) && !redirect_i;
    assign pop  = instr_valid_o && instr_ready_i && !redirect_i;

    // Next-state, credit and request decision from next-cycle occupancy.
    always_comb begin
        state_n    = state;
        inflight_n = inflight + OW'(hs) - OW'(imem_rvalid_i);
        discard_n  = discard;
        count_n    = count + CW'(push) - CW'(pop);
        live_n     = '0;
        credit_ok  = 1'b0;
        req_n      = 1'b0;

        if (redirect_i) begin
            discard_n = inflight_n;
            count_n   = '0;
        end else if (imem_rvalid_i && (discard != '0)) begin
            discard_n = discard - OW'(1);
        end

        live_n    = inflight_n - discard_n;
        credit_ok = ((SW'(count_n) + SW'(live_n)) < SW'(DEPTH)) && (inflight_n < OW'(MAX_OUT));

        case (state)
            IFU_BOOT:  state_n = IFU_FETCH;
            IFU_FETCH: if (!credit_ok) state_n = IFU_HOLD;
            IFU_HOLD:  if (credit_ok)  state_n = IFU_FETCH;
            default:   state_n = IFU_BOOT;
        endcase
        if (redirect_i) state_n = IFU_FETCH;

        req_n = (state_n == IFU_FETCH) && credit_ok;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IFU_BOOT;
            imem_req_o <= 1'b0;
            inflight   <= '0;
            discard    <= '0;
        end else begin
            state      <= state_n;
            imem_req_o <= req_n;
            inflight   <= inflight_n;
            discard    <= discard_n;
        end
    end

    // Fetch PC only moves on a handshake or redirect, keeping addr stable while req waits.
    always_ff @(posedge clk) begin
        if (reset) begin
            fpc <= RESET_PC;
        end else if (redirect_i) begin
            fpc <= redirect_pc_i & ~XLEN'(3);
        end else if (hs) begin
            fpc <= fpc + XLEN'(4);
        end
    end

    assign imem_addr_o = fpc;

    // PC tag queue: only live requests are tagged, so discarded responses never read it.
    always_ff @(posedge clk) begin
        if (reset || redirect_i) begin
            tw <= '0;
            tr <= '0;
        end else begin
            if (hs)   tw <= (tw == TW'(MAX_OUT - 1)) ? '0 : tw + TW'(1);
            if (push) tr <= (tr == TW'(MAX_OUT - 1)) ? '0 : tr + TW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (hs && !redirect_i) tag[tw] <= fpc;
    end

    cpu6_ifu_fifo #(
        .WIDTH (2 * XLEN),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (redirect_i),
        .din   ({tag[tr], imem_rdata_i}),
        .dout  (fifo_dout),
        .count (count)
    );

    assign instr_valid_o = (count != '0);
    assign instr_o       = instr_valid_o ? fifo_dout[XLEN-1:0] : XLEN'(CPU6_NOP);
    assign instr_pc_o    = instr_valid_o ? fifo_dout[2*XLEN-1:XLEN] : '0;

    a_rvalid_inflight: assert property (@(posedge clk) disable iff (reset)
        imem_rvalid_i |-> (inflight != '0));

    a_req_hold: assert property (@(posedge clk) disable iff (reset)
        (imem_req_o && !imem_gnt_i && !redirect_i) |=> (imem_req_o && $stable(imem_addr_o)));

endmodule
